// File: rtl/instruction_decode.sv
// Registered R-format decode stage: splits the instruction, reads two operands from a
// 32x32 register file and hands the result to execute through a one-entry valid/ready register.
module instruction_decode #(
    parameter int NREGS = 32,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [5:0]       function_code,
    output logic [WIDTH-1:0] data1,
    output logic [WIDTH-1:0] data2,
    output logic [4:0]       shamt,
    output logic [20:0]      constant,
    output logic             ALUSrc,
    output logic [4:0]       rd,
    output logic             illegal,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [WIDTH-1:0] wb_data
);

    // Handshake: a word moves when valid && ready on the same rising edge. Input side accepts
    // whenever the output register is empty or being drained; out_valid holds until out_ready.
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    logic             out_valid_q, out_valid_d;
    logic             illegal_q, illegal_d;
    logic [5:0]       funct_q, funct_d;
    logic [WIDTH-1:0] data1_q, data1_d;
    logic [WIDTH-1:0] data2_q, data2_d;
    logic [4:0]       shamt_q, shamt_d;
    logic [20:0]      const_q, const_d;
    logic             alusrc_q, alusrc_d;
    logic [4:0]       rd_q, rd_d;
    logic [4:0]       rs_q, rs_d;
    logic [4:0]       rt_q, rt_d;

    logic       accept;
    logic       legal;
    logic       wr_en;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [5:0] funct;

    assign instr_ready = !out_valid_q || out_ready;
    assign accept      = instr_valid && instr_ready;
    assign legal       = (instr[31:26] == 6'd0);
    assign wr_en       = wb_en && (wb_addr != 5'd0);
    assign rs          = instr[25:21];
    assign rt          = instr[20:16];
    assign funct       = instr[5:0];

    // Register 0 is never written, so it reads as its reset value of zero.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        illegal_d   = accept && !legal;
        funct_d     = funct_q;
        data1_d     = data1_q;
        data2_d     = data2_q;
        shamt_d     = shamt_q;
        const_d     = const_q;
        alusrc_d    = alusrc_q;
        rd_d        = rd_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        if (accept && legal) begin
            out_valid_d = 1'b1;
            funct_d     = funct;
            shamt_d     = instr[10:6];
            const_d     = instr[20:0];
            rd_d        = instr[15:11];
            rs_d        = rs;
            rt_d        = rt;
            alusrc_d    = !((funct == 6'b000000) || (funct == 6'b000010) ||
                            (funct == 6'b000011));
            data1_d     = (wr_en && (wb_addr == rs)) ? wb_data : regs_q[rs];
            data2_d     = (wr_en && (wb_addr == rt)) ? wb_data : regs_q[rt];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else if (out_valid_q) begin
            // Stalled: keep operands coherent with writebacks landing on the held sources.
            if (wr_en && (wb_addr == rs_q)) data1_d = wb_data;
            if (wr_en && (wb_addr == rt_q)) data2_d = wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            funct_q     <= '0;
            data1_q     <= '0;
            data2_q     <= '0;
            shamt_q     <= '0;
            const_q     <= '0;
            alusrc_q    <= 1'b0;
            rd_q        <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            funct_q     <= funct_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            shamt_q     <= shamt_d;
            const_q     <= const_d;
            alusrc_q    <= alusrc_d;
            rd_q        <= rd_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign illegal       = illegal_q;
    assign function_code = funct_q;
    assign data1         = data1_q;
    assign data2         = data2_q;
    assign shamt         = shamt_q;
    assign constant      = const_q;
    assign ALUSrc        = alusrc_q;
    assign rd            = rd_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Randomized scoreboard bench for instruction_decode: the driver pushes expected decodes,
// an independent monitor pops and compares on each output transfer.
module tb_instruction_decode;

    logic        clk;
    logic        reset_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        out_ready;
    logic        out_valid;
    logic [5:0]  function_code;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [4:0]  shamt;
    logic [20:0] constant;
    logic        ALUSrc;
    logic [4:0]  rd;
    logic        illegal;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    instruction_decode #(.NREGS(32), .WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .out_ready(out_ready), .out_valid(out_valid),
        .function_code(function_code), .data1(data1), .data2(data2), .shamt(shamt),
        .constant(constant), .ALUSrc(ALUSrc), .rd(rd), .illegal(illegal),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [20:0] konst;
        logic        alusrc;
        logic [4:0]  rd;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_regs [32];
    logic        m_valid;
    logic        m_illegal;
    logic        exp_ready;
    logic        mon_en;
    int          checks;
    int          failures;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_valid   = 1'b0;
        m_illegal = 1'b0;
        exp_ready = 1'b1;
        exp_q.delete();
    endtask

    // One clock cycle of stimulus; the model advances at the rising edge.
    task automatic cycle(input logic iv, input logic [31:0] ins, input logic ordy,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        logic acc;
        logic is_legal;
        exp_t e;
        @(negedge clk);
        instr_valid = iv;
        instr       = ins;
        out_ready   = ordy;
        wb_en       = we;
        wb_addr     = wa;
        wb_data     = wd;
        exp_ready   = !m_valid || ordy;
        @(posedge clk);
        acc      = iv && exp_ready;
        is_legal = (ins[31:26] == 6'd0);
        if (acc && is_legal) begin
            e.rs     = ins[25:21];
            e.rt     = ins[20:16];
            e.funct  = ins[5:0];
            e.shamt  = ins[10:6];
            e.konst  = ins[20:0];
            e.rd     = ins[15:11];
            e.alusrc = !(ins[5:0] inside {6'd0, 6'd2, 6'd3});
            exp_q.push_back(e);
        end
        m_illegal = acc && !is_legal;
        if (acc && is_legal) m_valid = 1'b1;
        else if (ordy)       m_valid = 1'b0;
        if (we && wa != 5'd0) m_regs[wa] = wd;
    endtask

    task automatic rand_cycle();
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rsv;
        logic [4:0] rtv;
        op  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
        rsv = 5'($urandom_range(0, 7));
        rtv = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
            0:       fn = 6'd0;
            1:       fn = 6'd2;
            2:       fn = 6'd3;
            default: fn = 6'($urandom_range(0, 63));
        endcase
        cycle(($urandom_range(0, 3) != 0),
              {op, rsv, rtv, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), fn},
              ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 7)), $urandom);
    endtask

    // Monitor: samples one time unit before each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (mon_en) begin
                chk("instr_ready", 32'(instr_ready), 32'(exp_ready));
                chk("out_valid", 32'(out_valid), 32'(m_valid));
                chk("illegal", 32'(illegal), 32'(m_illegal));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_transfer", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("function_code", 32'(function_code), 32'(e.funct));
                        chk("shamt", 32'(shamt), 32'(e.shamt));
                        chk("constant", 32'(constant), 32'(e.konst));
                        chk("ALUSrc", 32'(ALUSrc), 32'(e.alusrc));
                        chk("rd", 32'(rd), 32'(e.rd));
                        chk("data1", data1, m_regs[e.rs]);
                        chk("data2", data2, m_regs[e.rt]);
                    end
                end
            end
        end
    end

    initial begin
        checks      = 0;
        failures    = 0;
        mon_en      = 1'b0;
        reset_n     = 1'b0;
        instr       = 32'd0;
        instr_valid = 1'b0;
        out_ready   = 1'b0;
        wb_en       = 1'b0;
        wb_addr     = 5'd0;
        wb_data     = 32'd0;
        clear_model();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("reset_outputs", {26'd0, out_valid, illegal, ALUSrc, 3'd0},  32'd0);
        chk("reset_fields", {function_code, shamt, rd, 16'd0} | data1 | data2 | 32'(constant), 32'd0);
        mon_en = 1'b1;

        // Basic add: r3 = 0x10, r4 = 0x20
        cycle(1'b0, 32'd0, 1'b1, 1'b1, 5'd3, 32'h10);
        cycle(1'b0, 32'd0, 1'b1, 1'b1, 5'd4, 32'h20);
        cycle(1'b1, 32'h00642020, 1'b1, 1'b0, 5'd0, 32'd0);
        #1;
        chk("tp_add_valid", 32'(out_valid), 32'd1);
        chk("tp_add_data1", data1, 32'h10);
        chk("tp_add_data2", data2, 32'h20);
        chk("tp_add_funct", 32'(function_code), 32'h20);
        chk("tp_add_alusrc", 32'(ALUSrc), 32'd1);
        chk("tp_add_rd", 32'(rd), 32'd4);
        chk("tp_add_const", 32'(constant), 32'h042020);

        cycle(1'b1, 32'h00041040, 1'b1, 1'b0, 5'd0, 32'd0);
        #1;
        chk("tp_shift_alusrc", 32'(ALUSrc), 32'd0);
        chk("tp_shift_shamt", 32'(shamt), 32'd1);
        chk("tp_shift_data1", data1, 32'd0);

        cycle(1'b1, 32'h00642020, 1'b1, 1'b1, 5'd3, 32'hABCD);
        #1;
        chk("tp_bypass_data1", data1, 32'hABCD);
        cycle(1'b1, 32'h00042020, 1'b1, 1'b1, 5'd0, 32'h1234);
        #1;
        chk("tp_bypass_r0", data1, 32'd0);
        chk("tp_bypass_r0_data2", data2, 32'h20);

        cycle(1'b1, 32'h00642020, 1'b1, 1'b0, 5'd0, 32'd0);
        cycle(1'b0, 32'd0, 1'b0, 1'b1, 5'd3, 32'h55);
        #1;
        chk("tp_stall_refresh", data1, 32'h55);
        chk("tp_stall_ready", 32'(instr_ready), 32'd0);
        cycle(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("tp_stall_stable", {data2[15:0], 5'd0, rd, function_code}, {16'h20, 5'd0, 5'd4, 6'h20});
        cycle(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
        #1;
        chk("tp_stall_drain", 32'(out_valid), 32'd0);

        cycle(1'b1, 32'h20000000, 1'b1, 1'b0, 5'd0, 32'd0);
        #1;
        chk("tp_illegal_pulse", 32'(illegal), 32'd1);
        chk("tp_illegal_novalid", 32'(out_valid), 32'd0);
        cycle(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
        #1;
        chk("tp_illegal_once", 32'(illegal), 32'd0);

        repeat (500) rand_cycle();

        // Reset while an instruction is being held.
        cycle(1'b1, 32'h00642020, 1'b1, 1'b1, 5'd5, 32'h77);
        cycle(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        mon_en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("tp_reset_hold_valid", 32'(out_valid), 32'd0);
        chk("tp_reset_hold_data", data1 | data2, 32'd0);
        clear_model();
        instr_valid = 1'b0;
        out_ready   = 1'b0;
        wb_en       = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        cycle(1'b1, 32'h00642020, 1'b1, 1'b0, 5'd0, 32'd0);
        #1;
        chk("tp_reset_regs", data1 | data2, 32'd0);

        repeat (300) rand_cycle();
        repeat (3) cycle(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
